bsg_dff_skid_width_p4: RTL and testbench
========================================

Name: bsg_dff_skid_width_p4

Overview:
- Registered pipeline stage with a two-entry elastic buffer and full valid/ready handshaking.
- Reader-side counterpart of our plain free-running width-4 flop: instead of unconditionally capturing every cycle, it accepts data only when the producer offers it and releases it only when the consumer takes it.
- Sits between pipeline stages that need backpressure without combinational ready paths (e.g. between the bp_quad tile datapath and its consumers).
- Fully registered: no combinational path from input to output, and none from yumi_i to ready_o.

Parameters:
- width_p, 4, data width in bits (legal: >= 1).

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- v_i  input  1  producer offers data_i this cycle.
- data_i  input  width_p  producer data.
- ready_o  output  1  block accepts data this cycle; enqueue occurs iff v_i & ready_o.
- v_o  output  1  data_o holds valid data.
- data_o  output  width_p  head-of-buffer data.
- yumi_i  input  1  consumer takes data_o this cycle; legal only when v_o=1.
- els_o  output  2  occupancy, 0..2.

Behaviour:
- Storage
  - main_r: width_p bits; drives data_o.
  - skid_r: width_p bits.
  - state register: EMPTY, ONE, TWO.
- Reset, asserted asynchronously while reset_n_i=0:
  - state=EMPTY, v_o=0, ready_o=1, els_o=0, main_r=0, skid_r=0.
  - Deassertion is synchronised externally; the first edge after release behaves as normal EMPTY.
  - Reset mid-operation discards all buffered data immediately, without waiting for a clock edge.
- Output decode (registered state only):
  - v_o = (state!=EMPTY)
  - ready_o = (state!=TWO)
  - els_o = 0/1/2 for EMPTY/ONE/TWO
  - data_o = main_r
- enq = v_i & ready_o; deq = yumi_i & v_o.
- Transitions per rising edge:
  - EMPTY: enq -> ONE, main_r<=data_i. Otherwise stay. yumi_i ignored.
  - ONE:
    - enq & deq -> ONE, main_r<=data_i (pass-through, full throughput).
    - enq only -> TWO, skid_r<=data_i.
    - deq only -> EMPTY.
    - neither -> hold.
  - TWO:
    - ready_o=0, so v_i is ignored and data_i is not captured.
    - deq -> ONE, main_r<=skid_r.
    - no deq -> hold both entries.
- Latency: data enqueued at edge N appears on data_o/v_o after edge N (one cycle) when the buffer was EMPTY or when ONE with a simultaneous deq.
- Throughput: one transfer per cycle sustained while the consumer asserts yumi_i every cycle v_o=1.
- Ordering: strict FIFO; skid_r is always younger than main_r.
- data_o stable while v_o=1 and yumi_i=0.
- Illegal yumi_i with v_o=0: no state change; the bench flags it with an assertion.
- skid_r is written only on ONE->TWO, main_r only on enq into EMPTY/ONE or on TWO->ONE. No other writes.
- v_i may toggle freely; no requirement that it hold while ready_o=0.

Test Plan:
- Reset check:
  - Hold reset_n_i=0 with v_i=1, data_i=4'hA, pulse clocks -> v_o=0, ready_o=1, els_o=0, data_o=4'h0 throughout.
  - Assert reset asynchronously mid-cycle -> outputs clear before the next edge.
- Single transfer: EMPTY, v_i=1 data_i=4'h5 for one cycle, yumi_i=0 -> next cycle v_o=1, data_o=4'h5, els_o=1. Assert yumi_i -> following cycle v_o=0, els_o=0.
- Fill and stall:
  - Enqueue 4'h1, 4'h2, 4'h3 on consecutive cycles with yumi_i=0 -> els_o=2, ready_o=0, 4'h3 dropped, data_o=4'h1.
  - Then yumi_i=1 for two cycles -> data_o sequence 4'h1, 4'h2, then v_o=0.
- Streaming: v_i=1 and yumi_i=v_o every cycle, data_i counting 0..F -> data_o counts 0..F one cycle delayed, ready_o stays 1, els_o stays <=1.
- Simultaneous events in TWO: buffer holds 4'h7 (main), 4'h8 (skid); apply yumi_i=1 and v_i=1 data_i=4'h9 together -> 4'h9 not accepted (ready_o=0), next cycle data_o=4'h8, els_o=1, ready_o=1.
- Random backpressure: 10k cycles of random v_i/yumi_i with yumi_i gated by v_o; scoreboard checks:
  - in-order, lossless delivery;
  - data_o stable during stall;
  - no enq while ready_o=0;
  - els_o matches the model.

Source files
------------

// File: rtl/bsg_dff_skid_width_p4.sv
// Two-entry registered elastic pipeline stage with valid/ready handshaking.
//
// Handshake: the producer transfers data_i on a rising edge iff v_i & ready_o;
// the consumer takes data_o on a rising edge iff yumi_i & v_o. ready_o, v_o,
// els_o and data_o come only from registers, so there is no combinational
// path from any input to any output.
module bsg_dff_skid_width_p4 #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic [1:0]         els_o,
    output logic [1:0]         dbg_state_o
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [width_p-1:0] main_q, main_d;
    logic [width_p-1:0] skid_q, skid_d;
    logic               enq, deq;

    // Output decode depends on registered state only.
    always_comb begin
        v_o         = 1'b0;
        ready_o     = 1'b1;
        els_o       = 2'd0;
        case (state_q)
            ST_ONE: begin
                v_o     = 1'b1;
                ready_o = 1'b1;
                els_o   = 2'd1;
            end
            ST_TWO: begin
                v_o     = 1'b1;
                ready_o = 1'b0;
                els_o   = 2'd2;
            end
            default: begin
                v_o     = 1'b0;
                ready_o = 1'b1;
                els_o   = 2'd0;
            end
        endcase
        data_o      = main_q;
        dbg_state_o = state_q;
    end

    // Next-state and data-path selection; skid always holds the younger entry.
    always_comb begin
        enq     = v_i & ready_o;
        deq     = yumi_i & v_o;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (enq) begin
                    state_d = ST_ONE;
                    main_d  = data_i;
                end
            end
            ST_ONE: begin
                if (enq && deq) begin
                    main_d = data_i;
                end else if (enq) begin
                    state_d = ST_TWO;
                    skid_d  = data_i;
                end else if (deq) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (deq) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                // Unreachable encoding: recover to an empty buffer.
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State and storage registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_bsg_dff_skid_width_p4.sv
// Self-checking bench for bsg_dff_skid_width_p4: directed vectors followed by
// a randomized backpressure run scored against a queue model.
module tb_bsg_dff_skid_width_p4;

    localparam int W = 4;

    logic         clk_i;
    logic         reset_n_i;
    logic         v_i;
    logic [W-1:0] data_i;
    logic         ready_o;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         yumi_i;
    logic [1:0]   els_o;
    logic [1:0]   dbg_state_o;

    int n_total;
    int n_pass;
    logic [W-1:0] exp_q[$];

    bsg_dff_skid_width_p4 #(.width_p(W)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .v_i         (v_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .v_o         (v_o),
        .data_o      (data_o),
        .yumi_i      (yumi_i),
        .els_o       (els_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, ...
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Consumer must never take data that is not valid.
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(yumi_i && !v_o));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge; return 1 time unit after it.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic y);
        v_i    = v;
        data_i = d;
        yumi_i = y;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic r,
                           input logic [1:0] e, input logic [W-1:0] d);
        chk({tag, ".v_o"},     v_o,     v);
        chk({tag, ".ready_o"}, ready_o, r);
        chk({tag, ".els_o"},   els_o,   e);
        chk({tag, ".data_o"},  data_o,  d);
    endtask

    initial begin
        int nv;
        int ny;
        logic [W-1:0] nd;
        logic [W-1:0] head;
        n_total   = 0;
        n_pass    = 0;
        reset_n_i = 1'b0;
        drive(1'b1, 4'hA, 1'b0);

        // Reset held: offers must be ignored.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_out("reset_hold", 1'b0, 1'b1, 2'd0, 4'h0);
        end
        drive(1'b0, 4'h0, 1'b0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        cyc();
        chk_out("after_reset", 1'b0, 1'b1, 2'd0, 4'h0);

        // Single transfer.
        drive(1'b1, 4'h5, 1'b0);
        cyc();
        drive(1'b0, 4'h0, 1'b0);
        chk_out("single_enq", 1'b1, 1'b1, 2'd1, 4'h5);
        yumi_i = 1'b1;
        cyc();
        yumi_i = 1'b0;
        chk("single_deq.v_o", v_o, 1'b0);
        chk("single_deq.els_o", els_o, 2'd0);

        // Fill and stall: third offer is refused.
        drive(1'b1, 4'h1, 1'b0);
        cyc();
        data_i = 4'h2;
        cyc();
        data_i = 4'h3;
        chk("fill_full_pre.ready_o", ready_o, 1'b0);
        cyc();
        drive(1'b0, 4'h0, 1'b0);
        chk_out("fill_stall", 1'b1, 1'b0, 2'd2, 4'h1);
        yumi_i = 1'b1;
        cyc();
        chk_out("drain_1", 1'b1, 1'b1, 2'd1, 4'h2);
        cyc();
        yumi_i = 1'b0;
        chk_out("drain_2", 1'b0, 1'b1, 2'd0, 4'h2);

        // Streaming pass-through, one transfer per cycle.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i[W-1:0], v_o);
            cyc();
            chk_out($sformatf("stream_%0d", i), 1'b1, 1'b1, 2'd1, i[W-1:0]);
        end
        drive(1'b0, 4'h0, 1'b1);
        cyc();
        yumi_i = 1'b0;
        chk("stream_drain.v_o", v_o, 1'b0);

        // Simultaneous offer and take while full.
        drive(1'b1, 4'h7, 1'b0);
        cyc();
        data_i = 4'h8;
        cyc();
        chk_out("two_loaded", 1'b1, 1'b0, 2'd2, 4'h7);
        drive(1'b1, 4'h9, 1'b1);
        cyc();
        chk_out("two_deq_enq", 1'b1, 1'b1, 2'd1, 4'h8);
        drive(1'b0, 4'h0, 1'b1);
        cyc();
        yumi_i = 1'b0;
        chk_out("two_no_9", 1'b0, 1'b1, 2'd0, 4'h8);

        // Asynchronous reset mid-cycle discards buffered data.
        drive(1'b1, 4'hC, 1'b0);
        cyc();
        drive(1'b0, 4'h0, 1'b0);
        chk_out("pre_async", 1'b1, 1'b1, 2'd1, 4'hC);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 1'b1, 2'd0, 4'h0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        cyc();
        chk_out("async_release", 1'b0, 1'b1, 2'd0, 4'h0);

        // Random backpressure against a queue model.
        exp_q.delete();
        for (int c = 0; c < 10000; c++) begin
            chk("rnd.els_o",   els_o,   exp_q.size());
            chk("rnd.ready_o", ready_o, exp_q.size() < 2);
            chk("rnd.v_o",     v_o,     exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                chk("rnd.data_o", data_o, exp_q[0]);
            end
            nv = $urandom_range(0, 1);
            nd = W'($urandom_range(0, 15));
            ny = (exp_q.size() > 0) ? $urandom_range(0, 1) : 0;
            drive(nv[0], nd, ny[0]);
            if (ny != 0 && exp_q.size() > 0) begin
                head = exp_q.pop_front();
                if (nv != 0 && exp_q.size() == 0) begin
                    exp_q.push_back(nd);
                end else if (nv != 0 && exp_q.size() == 1) begin
                    // Was full: the offer is refused this cycle.
                end
            end else if (nv != 0 && exp_q.size() < 2) begin
                exp_q.push_back(nd);
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
